icache_intc_aux_sched: RTL and testbench
========================================

ICACHE_INTC_AUX_SCHED -- requirements
Module: icache_intc_aux_sched

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter UID_WIDTH, default 17, one-hot requester ID width.
REQ-003 SHALL have parameter CORE_WEIGHT, default 8, core grants per aux priority slot (legal range 1..255).
REQ-004 SHALL have parameter MAX_STARVE, default 16, aux wait cycles before forced aux priority (legal range 1..255).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4, in-flight request limit (legal range 1..15).
REQ-006 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have core side: req_core_i in 1; addr_core_i in ADDRESS_WIDTH; uid_core_i in UID_WIDTH; gnt_core_o out 1.
REQ-008 SHALL have aux side: req_aux_i in 1; addr_aux_i in ADDRESS_WIDTH; uid_aux_i in UID_WIDTH; gnt_aux_o out 1.
REQ-009 SHALL have bank side: request_o out 1; address_o out ADDRESS_WIDTH; UID_o out UID_WIDTH; grant_i in 1; response_i in 1 (one retired request).
REQ-010 SHALL have status: outstanding_o out $clog2(MAX_OUTSTANDING+1) current in-flight count; aux_pri_o out 1 FSM in AUX_PRI; err_o out 1 sticky underflow flag.

Function
REQ-011 SHALL implement FSM states CORE_PRI, AUX_PRI; aux_pri_o=1 only in AUX_PRI.
REQ-012 SHALL define credit_ok = (outstanding < MAX_OUTSTANDING); request_o = (req_core_i | req_aux_i) & credit_ok, combinational.
REQ-013 SHALL select winner: CORE_PRI -> core if req_core_i else aux; AUX_PRI -> aux if req_aux_i else core (work-conserving).
REQ-014 SHALL drive address_o/UID_o from winner; with no request, from core side.
REQ-015 SHALL assert gnt_core_o/gnt_aux_o = grant_i & request_o & winner-is-that-side; never both; zero-latency combinational grant.
REQ-016 SHALL count core handshakes in CORE_PRI in weight counter; on the handshake making it equal CORE_WEIGHT, next state AUX_PRI and counter cleared.
REQ-017 SHALL in AUX_PRI, on aux handshake, return to CORE_PRI next cycle; core handshakes in AUX_PRI do not touch weight counter.
REQ-018 SHALL increment starve counter each cycle req_aux_i=1 and gnt_aux_o=0, saturating at MAX_STARVE; clear on aux handshake or req_aux_i=0.
REQ-019 SHALL force next state AUX_PRI (weight counter cleared) when starve counter reaches MAX_STARVE, regardless of weight counter.
REQ-020 SHALL update outstanding: +1 on handshake only, -1 on response_i only, unchanged on both same cycle.
REQ-021 SHALL on response_i with outstanding=0 and no same-cycle handshake keep count 0 and set err_o until reset.
REQ-022 SHALL, at outstanding=MAX_OUTSTANDING, hold request_o=0 and both grants 0; a same-cycle response_i re-enables request next cycle, not same cycle.
REQ-023 SHALL not change state or counters when grant_i=1 with request_o=0.

Reset
REQ-024 SHALL asynchronously on rst_ni=0 set state CORE_PRI, weight, starve and outstanding counters 0, err_o 0; request_o/grants then depend only on inputs per REQ-012..015.
REQ-025 SHALL discard in-flight accounting on reset mid-operation; responses after reset with count 0 set err_o.

Structure
REQ-026 SHALL place FSM state enum and counter-width localparams in shared package icache_intc_pkg.
REQ-027 SHALL use one sub-module icache_intc_credit_cnt (outstanding counter, credit_ok, err_o); remainder flat.

Verification
REQ-028 SHALL test both requesting continuously, grant_i=1, response_i each cycle, CORE_WEIGHT=8 -> 8 core grants then 1 aux grant, repeating.
REQ-029 SHALL test only aux requesting in CORE_PRI -> aux granted every cycle, starve counter stays 0.
REQ-030 SHALL test both requesting, grant_i=1, MAX_STARVE=3, CORE_WEIGHT=255 -> aux granted within 4 cycles of first request.
REQ-031 SHALL test MAX_OUTSTANDING=4, no response_i -> exactly 4 handshakes, then request_o=0, outstanding_o=4; one response_i -> one further handshake next cycle.
REQ-032 SHALL test response_i at outstanding_o=0 -> err_o=1, stays 1 until rst_ni pulse.
REQ-033 SHALL test rst_ni asserted with outstanding_o=3, AUX_PRI -> immediately outstanding_o=0, aux_pri_o=0.

Source files
------------

// File: rtl/icache_intc_pkg.sv
// Shared types and counter widths for the icache interconnect
// core/aux request scheduler.
package icache_intc_pkg;

  typedef enum logic {
    CORE_PRI = 1'b0,
    AUX_PRI  = 1'b1
  } sched_state_e;

  // Sized for the largest legal CORE_WEIGHT / MAX_STARVE (255).
  localparam int unsigned WEIGHT_CNT_W = 8;
  localparam int unsigned STARVE_CNT_W = 8;

endpackage

// File: rtl/icache_intc_credit_cnt.sv
// In-flight request counter: credit check and sticky
// underflow flag for retire pulses with nothing in flight.
module icache_intc_credit_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               hs_i,
  input  logic                               rsp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count_o,
  output logic                               credit_ok_o,
  output logic                               err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          inc, dec;

  assign inc = hs_i & ~rsp_i;
  assign dec = rsp_i & ~hs_i;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (1'b1)
      inc: cnt_d = cnt_q + 1'b1;
      dec: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign count_o     = cnt_q;
  assign credit_ok_o = (cnt_q < MAX_C);
  assign err_o       = err_q;

endmodule

// File: rtl/icache_intc_aux_sched.sv
// Weighted core/aux arbiter in front of an icache bank with
// aux starvation guard and outstanding-request credit limit.
module icache_intc_aux_sched
  import icache_intc_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned UID_WIDTH       = 17,
  parameter int unsigned CORE_WEIGHT     = 8,
  parameter int unsigned MAX_STARVE      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_core_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_core_i,
  input  logic [UID_WIDTH-1:0]     uid_core_i,
  output logic                     gnt_core_o,
  input  logic                     req_aux_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_aux_i,
  input  logic [UID_WIDTH-1:0]     uid_aux_i,
  output logic                     gnt_aux_o,
  output logic                     request_o,
  output logic [ADDRESS_WIDTH-1:0] address_o,
  output logic [UID_WIDTH-1:0]     UID_o,
  input  logic                     grant_i,
  input  logic                     response_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                     aux_pri_o,
  output logic                     err_o
);

  localparam logic [WEIGHT_CNT_W-1:0] WEIGHT_C =
    WEIGHT_CNT_W'(CORE_WEIGHT);
  localparam logic [STARVE_CNT_W-1:0] STARVE_C =
    STARVE_CNT_W'(MAX_STARVE);

  sched_state_e state_q, state_d;
  logic [WEIGHT_CNT_W-1:0] weight_q, weight_d, weight_inc;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  logic credit_ok;
  logic aux_win;
  logic hs, core_hs, aux_hs;

  // Work-conserving: the favoured side yields when idle.
  assign aux_win = (state_q == AUX_PRI) ? req_aux_i
                 : (req_aux_i & ~req_core_i);

  assign request_o  = (req_core_i | req_aux_i) & credit_ok;
  assign address_o  = aux_win ? addr_aux_i : addr_core_i;
  assign UID_o      = aux_win ? uid_aux_i  : uid_core_i;
  assign hs         = grant_i & request_o;
  assign gnt_core_o = hs & ~aux_win;
  assign gnt_aux_o  = hs & aux_win;
  assign core_hs    = gnt_core_o;
  assign aux_hs     = gnt_aux_o;
  assign aux_pri_o  = (state_q == AUX_PRI);
  assign weight_inc = weight_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    weight_d = weight_q;
    starve_d = '0;
    if (req_aux_i && !gnt_aux_o) begin
      starve_d = (starve_q == STARVE_C) ? starve_q
               : starve_q + 1'b1;
    end
    unique case (state_q)
      CORE_PRI: begin
        if (core_hs) begin
          if (weight_inc == WEIGHT_C) begin
            state_d  = AUX_PRI;
            weight_d = '0;
          end else begin
            weight_d = weight_inc;
          end
        end
      end
      AUX_PRI: begin
        if (aux_hs) state_d = CORE_PRI;
      end
      default: state_d = CORE_PRI;
    endcase
    // Starvation overrides the weighted rotation.
    if (starve_d == STARVE_C) begin
      state_d  = AUX_PRI;
      weight_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CORE_PRI;
      weight_q <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      weight_q <= weight_d;
      starve_q <= starve_d;
    end
  end

  icache_intc_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .hs_i        (hs),
    .rsp_i       (response_i),
    .count_o     (outstanding_o),
    .credit_ok_o (credit_ok),
    .err_o       (err_o)
  );

endmodule

// File: tb/tb_icache_intc_aux_sched.sv
// Directed bench for the core/aux icache scheduler.
// Second instance uses CORE_WEIGHT=255, MAX_STARVE=3.
module tb_icache_intc_aux_sched;

  localparam int AW = 32;
  localparam int UW = 17;

  logic clk = 1'b0;
  logic rst_ni;
  logic rc, ra, gnt_i, rsp_i;
  logic [AW-1:0] addr_c, addr_a;
  logic [UW-1:0] uid_c, uid_a;

  logic gc, ga, req_o, apri, err;
  logic [AW-1:0] addr_o;
  logic [UW-1:0] uid_o;
  logic [2:0] outs;

  logic gc2, ga2, req2, apri2, err2;
  logic [AW-1:0] addr2;
  logic [UW-1:0] uid2;
  logic [2:0] outs2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_intc_aux_sched u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_core_i(rc), .addr_core_i(addr_c),
    .uid_core_i(uid_c), .gnt_core_o(gc),
    .req_aux_i(ra), .addr_aux_i(addr_a),
    .uid_aux_i(uid_a), .gnt_aux_o(ga),
    .request_o(req_o), .address_o(addr_o),
    .UID_o(uid_o), .grant_i(gnt_i),
    .response_i(rsp_i), .outstanding_o(outs),
    .aux_pri_o(apri), .err_o(err)
  );

  icache_intc_aux_sched #(
    .CORE_WEIGHT(255), .MAX_STARVE(3)
  ) u_dut_st (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_core_i(rc), .addr_core_i(addr_c),
    .uid_core_i(uid_c), .gnt_core_o(gc2),
    .req_aux_i(ra), .addr_aux_i(addr_a),
    .uid_aux_i(uid_a), .gnt_aux_o(ga2),
    .request_o(req2), .address_o(addr2),
    .UID_o(uid2), .grant_i(gnt_i),
    .response_i(rsp_i), .outstanding_o(outs2),
    .aux_pri_o(apri2), .err_o(err2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rc = 1'b0; ra = 1'b0;
    gnt_i = 1'b0; rsp_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_c = 32'h0000_1000; uid_c = 17'h00001;
    addr_a = 32'h0000_2000; uid_a = 17'h00002;
    idle();
    rst_ni = 1'b0;
    #12;
    chk("rst_outs", 64'(outs), 64'd0);
    chk("rst_apri", 64'(apri), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req", 64'(req_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // weighted rotation: 8 core then 1 aux
    do_reset();
    rc = 1; ra = 1; gnt_i = 1; rsp_i = 1;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk($sformatf("w_gc%0d", i), 64'(gc),
          64'((i % 9) != 8));
      chk($sformatf("w_ga%0d", i), 64'(ga),
          64'((i % 9) == 8));
      chk($sformatf("w_apri%0d", i), 64'(apri),
          64'((i % 9) == 8));
      chk($sformatf("w_addr%0d", i), 64'(addr_o),
          ((i % 9) == 8) ? 64'h2000 : 64'h1000);
      tick();
    end
    chk("w_outs", 64'(outs), 64'd0);
    chk("w_err", 64'(err), 64'd0);

    // aux alone in CORE_PRI
    do_reset();
    ra = 1; gnt_i = 1; rsp_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("a_ga%0d", i), 64'(ga), 64'd1);
      chk($sformatf("a_gc%0d", i), 64'(gc), 64'd0);
      chk($sformatf("a_uid%0d", i), 64'(uid_o), 64'd2);
      tick();
      chk($sformatf("a_starve%0d", i),
          64'(u_dut.starve_q), 64'd0);
      chk($sformatf("a_apri%0d", i), 64'(apri), 64'd0);
    end

    // starvation guard on the second instance
    do_reset();
    rc = 1; ra = 1; gnt_i = 1; rsp_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("s_ga%0d", i), 64'(ga2),
          64'(i == 3));
      chk($sformatf("s_gc%0d", i), 64'(gc2),
          64'(i != 3));
      chk($sformatf("s_apri%0d", i), 64'(apri2),
          64'(i == 3));
      tick();
    end

    // credit limit
    do_reset();
    rc = 1; gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("c_outs%0d", i), 64'(outs),
          64'(i));
      chk($sformatf("c_gc%0d", i), 64'(gc), 64'd1);
      tick();
    end
    #1;
    chk("c_full_outs", 64'(outs), 64'd4);
    chk("c_full_req", 64'(req_o), 64'd0);
    chk("c_full_gc", 64'(gc), 64'd0);
    tick();
    rsp_i = 1;
    #1;
    chk("c_rsp_req", 64'(req_o), 64'd0);
    chk("c_rsp_gc", 64'(gc), 64'd0);
    tick();
    rsp_i = 0;
    #1;
    chk("c_re_outs", 64'(outs), 64'd3);
    chk("c_re_req", 64'(req_o), 64'd1);
    chk("c_re_gc", 64'(gc), 64'd1);
    tick();
    #1;
    chk("c_re2_outs", 64'(outs), 64'd4);
    chk("c_re2_req", 64'(req_o), 64'd0);
    chk("c_apri", 64'(apri), 64'd0);

    // underflow and grant without request
    do_reset();
    rsp_i = 1;
    tick();
    rsp_i = 0;
    chk("u_err", 64'(err), 64'd1);
    chk("u_outs", 64'(outs), 64'd0);
    gnt_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("u_req%0d", i), 64'(req_o), 64'd0);
      chk($sformatf("u_g%0d", i), 64'({gc, ga}), 64'd0);
      tick();
      chk($sformatf("u_hold%0d", i), 64'(err), 64'd1);
      chk($sformatf("u_st%0d", i),
          64'({apri, outs}), 64'd0);
    end
    do_reset();
    chk("u_clr", 64'(err), 64'd0);

    // reset in AUX_PRI with 3 in flight
    do_reset();
    rc = 1; ra = 1; gnt_i = 1; rsp_i = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("r_apri", 64'(apri), 64'd1);
    ra = 0; rsp_i = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("r_outs3", 64'(outs), 64'd3);
    chk("r_apri3", 64'(apri), 64'd1);
    rc = 0; gnt_i = 0;
    rst_ni = 1'b0;
    #1;
    chk("r_outs0", 64'(outs), 64'd0);
    chk("r_apri0", 64'(apri), 64'd0);
    rst_ni = 1'b1;
    tick();
    rsp_i = 1;
    tick();
    rsp_i = 0;
    chk("r_err", 64'(err), 64'd1);
    chk("r_outs", 64'(outs), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
